// File: rtl/menu_ctrl_if.sv
// Menu controller signal bundle: synchronised button levels and frame/game events in,
// screen select, cursor and game-start pulse out.
interface menu_ctrl_if;
   logic       frame_start;
   logic       btn_up;
   logic       btn_down;
   logic       btn_enter;
   logic       btn_back;
   logic       game_over;
   logic [1:0] select_text;
   logic [1:0] cursor;
   logic       menu_active;
   logic       start_game;

   modport master (
      output frame_start, btn_up, btn_down, btn_enter, btn_back, game_over,
      input  select_text, cursor, menu_active, start_game
   );

   modport slave (
      input  frame_start, btn_up, btn_down, btn_enter, btn_back, game_over,
      output select_text, cursor, menu_active, start_game
   );
endinterface

// File: rtl/menu_ctrl.sv
// Menu navigation FSM: button presses and game_over drive screen state, cursor and text select.
// Optional idle auto-return to TITLE is built only when MENU_CTRL_TIMEOUT_EN is defined.
module menu_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 650_000_000
) (
   input  logic       clk,
   input  logic       rst,
   menu_ctrl_if.slave bus
);
   typedef enum logic [2:0] {TITLE, SETTINGS, HELP, PLAYING, OVER} state_t;

   state_t     state;
   state_t     state_next;
   logic [1:0] cursor_next;
   logic       prev_up, prev_down, prev_enter, prev_back;
   logic       press_up, press_down, press_enter, press_back, any_press;
   logic       act_up, act_down, act_enter, act_back;
   logic       timeout_hit;

   // Previous levels reset high so a button held through reset is not seen as a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_up    <= 1'b1;
         prev_down  <= 1'b1;
         prev_enter <= 1'b1;
         prev_back  <= 1'b1;
      end else begin
         prev_up    <= bus.btn_up;
         prev_down  <= bus.btn_down;
         prev_enter <= bus.btn_enter;
         prev_back  <= bus.btn_back;
      end
   end

   assign press_up    = bus.btn_up    & ~prev_up;
   assign press_down  = bus.btn_down  & ~prev_down;
   assign press_enter = bus.btn_enter & ~prev_enter;
   assign press_back  = bus.btn_back  & ~prev_back;
   assign any_press   = press_up | press_down | press_enter | press_back;

   // Only the highest-priority press is considered; if the screen ignores it, nothing happens.
   assign act_back  = press_back;
   assign act_enter = press_enter & ~press_back;
   assign act_up    = press_up & ~press_back & ~press_enter;
   assign act_down  = press_down & ~press_back & ~press_enter & ~press_up;

`ifdef MENU_CTRL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] idle_cnt;
   logic             idle_state;

   assign idle_state  = (state == SETTINGS) || (state == HELP) || (state == OVER);
   assign timeout_hit = idle_state && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         idle_cnt <= '0;
      else if (!idle_state || any_press || (state_next != state))
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_next  = state;
      cursor_next = bus.cursor;
      case (state)
         TITLE: begin
            if (act_enter) begin
               case (bus.cursor)
                  2'd0:    state_next = PLAYING;
                  2'd1:    state_next = SETTINGS;
                  default: state_next = HELP;
               endcase
            end else if (act_up && (bus.cursor != 2'd0)) begin
               cursor_next = bus.cursor - 2'd1;
            end else if (act_down && (bus.cursor < 2'd2)) begin
               cursor_next = bus.cursor + 2'd1;
            end
         end
         SETTINGS: begin
            if (act_back)
               state_next = TITLE;
            else if (act_up && (bus.cursor != 2'd0))
               cursor_next = bus.cursor - 2'd1;
            else if (act_down && (bus.cursor == 2'd0))
               cursor_next = 2'd1;
         end
         HELP: begin
            if (act_enter || act_back)
               state_next = TITLE;
         end
         PLAYING: begin
            if (bus.game_over)
               state_next = OVER;
         end
         OVER: begin
            if (act_back)
               state_next = TITLE;
            else if (act_enter)
               state_next = PLAYING;
         end
         default: state_next = TITLE;
      endcase
      if (timeout_hit && !any_press)
         state_next = TITLE;
      if (state_next != state)
         cursor_next = 2'd0;
   end

   // Text select and overlay flag sample the current state only on frame_start,
   // so the text set never switches mid-frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= TITLE;
         bus.cursor      <= 2'd0;
         bus.start_game  <= 1'b0;
         bus.select_text <= 2'b00;
         bus.menu_active <= 1'b1;
      end else begin
         state          <= state_next;
         bus.cursor     <= cursor_next;
         bus.start_game <= (state_next == PLAYING) && (state != PLAYING);
         if (bus.frame_start) begin
            if (state == PLAYING) begin
               bus.menu_active <= 1'b0;
            end else begin
               bus.menu_active <= 1'b1;
               case (state)
                  SETTINGS: bus.select_text <= 2'b01;
                  HELP:     bus.select_text <= 2'b10;
                  OVER:     bus.select_text <= 2'b11;
                  default:  bus.select_text <= 2'b00;
               endcase
            end
         end
      end
   end
endmodule
